// File: rtl/alarm_rom_reader.sv
// alarm_rom_reader
// ----------------
// Avalon-MM read master for the Alarm on-chip program/data memory. A command
// (start word address + word count) is turned into a run of single-cycle read
// strobes. The returned words are buffered in a small FIFO and streamed out
// an Avalon-ST source with ready/valid backpressure and sop/eop framing.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_addr          start word address (must be < MEM_WORDS)
//   cmd_len           word count, 0 is legal (completes with no reads)
//   busy              high whenever a command is in progress
//   done              one-cycle completion pulse
//   m_*               Avalon-MM master towards the memory slave (read only)
//   st_data/valid     streamed words, held stable while not accepted
//   st_ready          sink accept
//   st_sop/st_eop     first / last word of the command

module alarm_rom_reader #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int MEM_WORDS    = 25600,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_len,
  output logic              busy,
  output logic              done,

  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_debugaccess,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,

  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

  logic [1:0]              state;
  logic                    armed;
  logic [ADDR_W-1:0]       addr;
  logic [15:0]             remaining;
  logic                    first_pending;
  logic                    done_q;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_sop;
  logic [READ_LATENCY-1:0] pipe_eop;
  logic [CNT_W-1:0]        inflight;

  logic [DATA_W-1:0]       fifo_data [FIFO_DEPTH];
  logic                    fifo_sop  [FIFO_DEPTH];
  logic                    fifo_eop  [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;

  logic accept;
  logic credit_ok;
  logic issue;
  logic last_issue;
  logic tap;
  logic push;
  logic pop;
  logic eop_xfer;

  // Write side of the memory port is unused; these are constant.
  assign m_write       = 1'b0;
  assign m_writedata   = '0;
  assign m_byteenable  = 4'hF;
  assign m_debugaccess = 1'b0;
  assign m_clken       = 1'b1;

  // armed keeps cmd_ready low while reset is held and for the partial cycle
  // in which it is released.
  assign cmd_ready = armed && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Every issued read owns a FIFO slot from strobe until it is popped, so
  // the buffer can never overflow whatever the sink does.
  assign credit_ok  = (({1'b0, count} + {1'b0, inflight}) < DEPTH_C);
  assign issue      = (state == S_ISSUE) && (remaining != 16'd0) && credit_ok;
  assign last_issue = issue && (remaining == 16'd1);

  assign m_chipselect = issue;
  assign m_address    = issue ? addr : '0;

  assign tap  = pipe_vld[READ_LATENCY-1];
  assign push = tap;

  assign st_valid = (count != '0);
  assign pop      = st_valid && st_ready;

  // Head outputs are gated so they read zero whenever the buffer is empty
  // (including during reset, where the storage itself is not cleared).
  assign st_data = st_valid ? fifo_data[rd_ptr] : '0;
  assign st_sop  = st_valid && fifo_sop[rd_ptr];
  assign st_eop  = st_valid && fifo_eop[rd_ptr];

  assign eop_xfer = (state == S_DRAIN) && (inflight == '0) && pop && st_eop;

  // Zero-length commands complete from a register one cycle after accept;
  // normal commands complete combinationally on the eop transfer.
  assign done = done_q || eop_xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      armed         <= 1'b0;
      addr          <= '0;
      remaining     <= '0;
      first_pending <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      armed  <= 1'b1;
      done_q <= accept && (cmd_len == 16'd0);

      case (state)
        S_IDLE: begin
          if (accept) begin
            addr          <= cmd_addr;
            remaining     <= cmd_len;
            first_pending <= 1'b1;
            if (cmd_len != 16'd0) begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr          <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
            remaining     <= remaining - 16'd1;
            first_pending <= 1'b0;
            if (last_issue) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (eop_xfer) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-latency shadow: each stage carries valid plus the sop/eop tags of
  // the read it represents, so framing travels with the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_sop <= '0;
      pipe_eop <= '0;
    end else begin
      pipe_vld[0] <= issue;
      pipe_sop[0] <= issue && first_pending;
      pipe_eop[0] <= last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_sop[i] <= pipe_sop[i-1];
        pipe_eop[i] <= pipe_eop[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({issue, tap})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= m_readdata;
      fifo_sop[wr_ptr]  <= pipe_sop[READ_LATENCY-1];
      fifo_eop[wr_ptr]  <= pipe_eop[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
